// File: rtl/layer_accum_pkg.sv
// layer_accum_pkg: shared widths, default quantization parameters and the FSM state type
package layer_accum_pkg;
  localparam int BIAS_W = 18;
  localparam int IN_W = 18;
  localparam int DEF_OUT_W = 8;
  localparam int DEF_SHIFT = 8;
  typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;
endpackage

// File: rtl/layer_accum_lane.sv
// layer_accum_lane: one output channel -- accumulator, bias add, optional ReLU, shift and saturate
// Ports: clk/rst; i_beat accepted beat, i_last final beat of group; i_din/i_bias signed 18-bit
// lane operands; o_q registered quantized result. Macro LAYER_ACCUM_RELU_EN selects ReLU + unsigned saturation.
module layer_accum_lane import layer_accum_pkg::*; #(
  parameter int ACC_W = 26,
  parameter int SHIFT = DEF_SHIFT,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_beat,
  input  logic                     i_last,
  input  logic signed [IN_W-1:0]   i_din,
  input  logic signed [BIAS_W-1:0] i_bias,
  output logic [OUT_W-1:0]         o_q
);
  logic signed [ACC_W-1:0] r_acc, w_sum, w_s, w_r, w_sh;
`ifdef LAYER_ACCUM_RELU_EN
  localparam logic signed [ACC_W-1:0] HI = ACC_W'((longint'(1) << OUT_W) - 1);
  localparam logic signed [ACC_W-1:0] LO = '0;
  assign w_r = w_s[ACC_W-1] ? '0 : w_s;
`else
  localparam logic signed [ACC_W-1:0] HI = ACC_W'((longint'(1) << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] LO = ~HI;
  assign w_r = w_s;
`endif
  assign w_sum = r_acc + ACC_W'(i_din);
  assign w_s = w_sum + ACC_W'(i_bias);
  assign w_sh = w_r >>> SHIFT;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      o_q <= '0;
    end else if (i_beat) begin
      r_acc <= i_last ? '0 : w_sum;
      if (i_last) o_q <= w_sh > HI ? HI[OUT_W-1:0] : w_sh < LO ? LO[OUT_W-1:0] : w_sh[OUT_W-1:0];
    end
  end
endmodule

// File: rtl/layer_accum_bias.sv
// layer_accum_bias: per-lane accumulation of adder-tree partial sums, bias add and output quantization
// Ports: in_data/in_valid/in_last/in_ready input beats; bias per-lane bias; out_data/out_valid/out_ready
// quantized result stream; err_overrun sticky group-too-long flag. Macro LAYER_ACCUM_RELU_EN enables ReLU.
module layer_accum_bias import layer_accum_pkg::*; #(
  parameter int N_adder_tree = 16,
  parameter int ACC_W = 26,
  parameter int MAX_BEATS = 64,
  parameter int SHIFT = DEF_SHIFT,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_adder_tree*IN_W-1:0]    in_data,
  input  logic                            in_valid,
  input  logic                            in_last,
  output logic                            in_ready,
  input  logic [N_adder_tree*BIAS_W-1:0]  bias,
  output logic [N_adder_tree*OUT_W-1:0]   out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            err_overrun
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic r_err, w_beat, w_fin, w_full;
  // HOLD can still take beats when the held result drains this cycle, so groups run back to back
  assign in_ready = (r_state == ST_ACC) || out_ready;
  assign w_beat = in_valid && in_ready;
  assign w_fin = w_beat && in_last;
  assign w_full = r_cnt == CNT_W'(MAX_BEATS);
  assign out_valid = r_state == ST_HOLD;
  assign err_overrun = r_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACC;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_fin ? ST_HOLD : (out_valid && out_ready) ? ST_ACC : r_state;
      if (w_beat) r_cnt <= in_last ? '0 : w_full ? r_cnt : r_cnt + 1'b1;
      if (w_beat && w_full) r_err <= 1'b1;
    end
  end
  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    layer_accum_lane #(.ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_lane (
      .clk(clk),
      .rst(rst),
      .i_beat(w_beat),
      .i_last(in_last),
      .i_din(in_data[IN_W*i +: IN_W]),
      .i_bias(bias[BIAS_W*i +: BIAS_W]),
      .o_q(out_data[OUT_W*i +: OUT_W])
    );
  end
endmodule

// File: tb/tb_layer_accum_bias.sv
// tb_layer_accum_bias: scoreboard bench for layer_accum_bias
module tb_layer_accum_bias;
  localparam int N = 16, OUT_W = 8, SHIFT = 8, MAXB = 64, ACC_W = 26, IW = 18;
  logic clk = 0, rst = 1;
  logic [N*IW-1:0] in_data = '0, bias = '0;
  logic in_valid = 0, in_last = 0, in_ready, out_valid, out_ready = 1, err_overrun;
  logic [N*OUT_W-1:0] out_data;
  int n_vec = 0, n_err = 0;
  int m_acc[N], d_in[N], d_b[N];
  int m_cnt = 0;
  logic m_err = 0;
  logic [N*OUT_W-1:0] exp_q[$];
  logic [N*OUT_W-1:0] held;

  layer_accum_bias #(.N_adder_tree(N), .ACC_W(ACC_W), .MAX_BEATS(MAXB), .SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .bias(bias), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [OUT_W-1:0] quant(input int s);
    int q;
`ifdef LAYER_ACCUM_RELU_EN
    if (s < 0) s = 0;
    q = s >>> SHIFT;
    if (q > (1 << OUT_W) - 1) q = (1 << OUT_W) - 1;
`else
    q = s >>> SHIFT;
    if (q > (1 << (OUT_W - 1)) - 1) q = (1 << (OUT_W - 1)) - 1;
    if (q < -(1 << (OUT_W - 1))) q = -(1 << (OUT_W - 1));
`endif
    return q[OUT_W-1:0];
  endfunction

  task automatic set_lanes(input int d0, input int b0, input int seed);
    d_in[0] = d0;
    d_b[0] = b0;
    for (int i = 1; i < N; i++) begin
      d_in[i] = ((i * 7919 + seed * 131) % 4001) - 2000;
      d_b[i] = i * 53 - 400 + seed;
    end
  endtask

  task automatic send_beat(input bit last);
    bit ok = 0;
    logic [N*OUT_W-1:0] e;
    for (int i = 0; i < N; i++) begin
      in_data[IW*i +: IW] = IW'(d_in[i]);
      bias[IW*i +: IW] = IW'(d_b[i]);
    end
    in_valid = 1;
    in_last = last;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      in_valid = 0;
      chk("in_ready_timeout", 0, 1);
      return;
    end
    @(posedge clk);
    #1;
    if (m_cnt == MAXB) m_err = 1;
    else if (!last) m_cnt++;
    if (last) begin
      m_cnt = 0;
      for (int i = 0; i < N; i++) begin
        e[OUT_W*i +: OUT_W] = quant(m_acc[i] + d_in[i] + d_b[i]);
        m_acc[i] = 0;
      end
      exp_q.push_back(e);
    end else begin
      for (int i = 0; i < N; i++) m_acc[i] += d_in[i];
    end
    chk("err_overrun", err_overrun, m_err);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    in_last = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    in_valid = 0;
    in_last = 0;
    rst = 1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 0;
    exp_q.delete();
    for (int i = 0; i < N; i++) m_acc[i] = 0;
    m_cnt = 0;
    m_err = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else chk("out_data", out_data, exp_q.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) m_acc[i] = 0;
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", err_overrun, 0);
    chk("rst_in_ready", in_ready, 1);

    set_lanes(1000, -400, 1);
    send_beat(1);
    chk("single_latency", out_valid, 1);
    chk("single_lane0", out_data[7:0], 8'd2);
    idle(2);
    chk("single_drop_valid", out_valid, 0);

    set_lanes(131071, 0, 2);
    for (int i = 1; i < N; i++) d_in[i] = (i % 2) ? -131072 : 131071;
    for (int b = 0; b < 3; b++) send_beat(b == 2);
`ifdef LAYER_ACCUM_RELU_EN
    chk("sat_lane0", out_data[7:0], 8'd255);
`else
    chk("sat_lane0", out_data[7:0], 8'd127);
`endif
    idle(1);

    set_lanes(-1000, 0, 3);
    send_beat(1);
`ifdef LAYER_ACCUM_RELU_EN
    chk("neg_lane0", out_data[7:0], 8'd0);
`else
    chk("neg_lane0", out_data[7:0], 8'hFC);
`endif
    idle(1);

    out_ready = 0;
    set_lanes(5000, 300, 4);
    send_beat(1);
    in_valid = 0;
    held = exp_q[0];
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_hold_data", out_data, held);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    set_lanes(-7000, 1200, 5);
    out_ready = 1;
    send_beat(1);
    chk("bp_no_bubble", out_valid, 1);
    chk("bp_next_data", out_data, exp_q[0]);
    idle(2);

    set_lanes(1000, 0, 6);
    for (int b = 0; b < 3; b++) send_beat(0);
    do_reset();
    set_lanes(512, 0, 7);
    send_beat(1);
    chk("rst_mid_lane0", out_data[7:0], 8'd2);
    idle(1);

    set_lanes(0, 0, 8);
    for (int i = 0; i < N; i++) begin
      d_in[i] = i * 10 + 1;
      d_b[i] = 0;
    end
    for (int b = 0; b < MAXB; b++) send_beat(0);
    chk("overrun_not_yet", err_overrun, 0);
    send_beat(0);
    chk("overrun_set", err_overrun, 1);
    idle(3);
    chk("overrun_sticky", err_overrun, 1);
    send_beat(1);
    idle(2);
    chk("overrun_still_set", err_overrun, 1);
    do_reset();
    chk("overrun_cleared", err_overrun, 0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/layer_accum_bias.md
LAYER_ACCUM_BIAS -- requirements
Module: layer_accum_bias

Interface
- REQ-001 SHALL have parameter N_adder_tree, default 16, number of parallel output-channel lanes.
- REQ-002 SHALL have parameter ACC_W, default 26, per-lane signed accumulator width.
- REQ-003 SHALL have parameter MAX_BEATS, default 64, maximum input beats per accumulation group.
- REQ-004 SHALL have parameter SHIFT, default 8, arithmetic right-shift applied before output quantization.
- REQ-005 SHALL have parameter OUT_W, default 8, per-lane output width.
- REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
- REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
- REQ-008 SHALL have port in_data, input, N_adder_tree*18, signed 18-bit adder-tree partial sums; lane i is bits [18*(i+1)-1:18*i].
- REQ-009 SHALL have port in_valid, input, 1, in_data/in_last valid.
- REQ-010 SHALL have port in_last, input, 1, final beat of the current group.
- REQ-011 SHALL have port in_ready, output, 1, beat accepted when in_valid && in_ready.
- REQ-012 SHALL have port bias, input, N_adder_tree*18, signed 18-bit per-lane bias, same lane packing and fixed-point format as in_data, static while a group is in flight.
- REQ-013 SHALL have port out_data, output, N_adder_tree*OUT_W, quantized per-lane results.
- REQ-014 SHALL have port out_valid, output, 1, out_data valid.
- REQ-015 SHALL have port out_ready, input, 1, consumer accepts when out_valid && out_ready.
- REQ-016 SHALL have port err_overrun, output, 1, sticky flag for a group exceeding MAX_BEATS.

Function
- REQ-017 SHALL implement states ACC and HOLD; ACC goes to HOLD on an accepted in_last beat; HOLD goes to ACC on an output handshake, unless an in_last beat is accepted in the same cycle, in which case it stays in HOLD.
- REQ-018 SHALL drive in_ready = (state==ACC) || out_ready, a combinational single-cycle skid with no bubble between groups.
- REQ-019 SHALL, on an accepted non-last beat, set per lane acc <= acc + sext(in_data lane) and increment beat_cnt.
- REQ-020 SHALL, on an accepted last beat, compute per lane s = acc + sext(in_data lane) + sext(bias lane), quantize s, register the result into out_data, set out_valid, clear acc to 0 and clear beat_cnt to 0, all in the same cycle.
- REQ-021 SHALL give a latency of 1 cycle, i.e. out_valid asserts in the cycle after the last beat is accepted.
- REQ-022 SHALL quantize as q = s >>> SHIFT (arithmetic, floor), then saturate to the OUT_W range defined in REQ-029/REQ-030.
- REQ-023 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
- REQ-024 SHALL deassert out_valid after the handshake unless a new result loads in the same cycle.
- REQ-025 SHALL treat a single-beat group (in_last on the first beat) as valid, giving s = in_data + bias.
- REQ-026 SHALL, when beat_cnt reaches MAX_BEATS and a further beat is accepted, set err_overrun (sticky until reset) while accumulation continues; ACC_W SHALL be at least 18+clog2(MAX_BEATS)+1.

Reset
- REQ-027 SHALL, on rst, set state=ACC, all acc=0, beat_cnt=0, out_valid=0, out_data=0 and err_overrun=0.
- REQ-028 SHALL discard any partial group or held output on rst asserted mid-group; the first beat after rst starts a new group.

Configuration
- REQ-029 SHALL, with macro LAYER_ACCUM_RELU_EN defined, apply ReLU (negative s becomes 0) before the shift and saturate out_data unsigned to 0..2^OUT_W-1.
- REQ-030 SHALL, without LAYER_ACCUM_RELU_EN, skip ReLU and saturate out_data signed to -2^(OUT_W-1)..2^(OUT_W-1)-1.

Structure
- REQ-031 SHALL place the constants BIAS_W=18 and IN_W=18, the default OUT_W and SHIFT, and the state enum type in shared package layer_accum_pkg.
- REQ-032 SHALL use one sub-module, layer_accum_lane, instantiated N_adder_tree times, holding acc plus the add/ReLU/shift/saturate datapath; the FSM, beat_cnt and handshake SHALL live in the top level.

Verification
- REQ-033 SHALL verify a single beat: lane0 in_data=1000, bias=-400, in_last=1 -> next cycle out_valid=1, out lane0=2 (600>>>8).
- REQ-034 SHALL verify saturation: 3 beats of in_data=131071, bias=0 -> s=393213, shifted 1535 -> out 255 (RELU_EN) or 127 (signed).
- REQ-035 SHALL verify negative values: in_data=-1000, bias=0 -> out 0 with RELU_EN; out -4 without it.
- REQ-036 SHALL verify backpressure: hold out_ready=0 for 5 cycles after a result -> out_data stable, in_ready=0 in HOLD; raise out_ready alongside the next group's last beat -> new result the next cycle with no bubble.
- REQ-037 SHALL verify reset mid-group: 3 of 5 beats, then rst, then a 1-beat group of 512 with bias=0 -> out=2, with no residue from the earlier beats.
- REQ-038 SHALL verify overrun: MAX_BEATS+1 beats without in_last -> err_overrun=1, remaining set until rst.
